// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes them to
// instruction memory while holding fetch/decode. Define IMEM_LOADER_CHECKSUM_EN for a trailing checksum byte.
module imem_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Load_Start_In,
  input  logic [ADDR_WIDTH:0]   Load_Count_In,
  input  logic [7:0]            Byte_In,
  input  logic                  Byte_Valid_In,
  output logic                  Byte_Ready_Out,
  output logic                  Mem_Write_En_Out,
  output logic [ADDR_WIDTH-1:0] Mem_Addr_Out,
  output logic [31:0]           Mem_Data_Out,
  output logic                  Pipeline_Hold_Out,
  output logic                  Load_Done_Out,
  output logic                  Load_Error_Out
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERROR, S_CSUM} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERROR} state_t;
`endif

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [1:0]            r_idx, w_idx_nxt;
  logic [ADDR_WIDTH:0]   r_left, w_left_nxt;
  logic [TW-1:0]         r_to, w_to_nxt;
  logic [31:0]           r_word, w_word_nxt;
  logic [ADDR_WIDTH-1:0] r_maddr, w_maddr_nxt;
  logic [31:0]           r_mdata, w_mdata_nxt;
  logic                  r_ready, w_ready_nxt;
  logic                  r_wen, w_wen_nxt;
  logic                  r_hold, w_hold_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;
  logic                  w_xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            r_csum, w_csum_nxt, w_csum_chk;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_idx   <= '0;
      r_left  <= '0;
      r_to    <= '0;
      r_word  <= '0;
      r_maddr <= '0;
      r_mdata <= '0;
      r_ready <= 1'b0;
      r_wen   <= 1'b0;
      r_hold  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_idx   <= w_idx_nxt;
      r_left  <= w_left_nxt;
      r_to    <= w_to_nxt;
      r_word  <= w_word_nxt;
      r_maddr <= w_maddr_nxt;
      r_mdata <= w_mdata_nxt;
      r_ready <= w_ready_nxt;
      r_wen   <= w_wen_nxt;
      r_hold  <= w_hold_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum  <= w_csum_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_idx_nxt   = r_idx;
    w_left_nxt  = r_left;
    w_to_nxt    = r_to;
    w_word_nxt  = r_word;
    w_maddr_nxt = r_maddr;
    w_mdata_nxt = r_mdata;
    w_err_nxt   = r_err;
    w_xfer      = Byte_Valid_In && r_ready;
`ifdef IMEM_LOADER_CHECKSUM_EN
    w_csum_nxt  = r_csum;
    w_csum_chk  = r_csum + Byte_In;
`endif
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Load_Start_In) begin
          w_left_nxt  = Load_Count_In;
          w_addr_nxt  = BASE;
          w_idx_nxt   = '0;
          w_to_nxt    = '0;
          w_err_nxt   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_csum_nxt  = '0;
`endif
          w_state_nxt = (Load_Count_In == '0) ? S_DONE : S_RECV;
        end else if (r_state == S_DONE) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RECV: begin
        if (w_xfer) begin
          w_word_nxt[{r_idx, 3'b000} +: 8] = Byte_In;
          w_idx_nxt = r_idx + 2'd1;
          w_to_nxt  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_csum_nxt = w_csum_chk;
`endif
          // The fourth byte goes straight to the write register so the word never waits a cycle
          if (r_idx == 2'd3) begin
            w_state_nxt = S_WRITE;
            w_mdata_nxt = {Byte_In, r_word[23:0]};
            w_maddr_nxt = r_addr;
          end
        end else if (r_to == TO_LAST) begin
          w_state_nxt = S_ERROR;
          w_err_nxt   = 1'b1;
        end else begin
          w_to_nxt = r_to + 1'b1;
        end
      end
      S_WRITE: begin
        w_left_nxt = r_left - 1'b1;
        w_to_nxt   = '0;
        if (r_left == (ADDR_WIDTH+1)'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_nxt = S_CSUM;
`else
          w_state_nxt = S_DONE;
`endif
        end else begin
          w_addr_nxt  = r_addr + 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_xfer) begin
          w_state_nxt = (w_csum_chk == 8'h00) ? S_DONE : S_ERROR;
          w_err_nxt   = (w_csum_chk != 8'h00);
        end else if (r_to == TO_LAST) begin
          w_state_nxt = S_ERROR;
          w_err_nxt   = 1'b1;
        end else begin
          w_to_nxt = r_to + 1'b1;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase

    // Output flags are derived from the next state so every output is a plain register
    w_ready_nxt = (w_state_nxt == S_RECV);
`ifdef IMEM_LOADER_CHECKSUM_EN
    w_ready_nxt = w_ready_nxt || (w_state_nxt == S_CSUM);
`endif
    w_hold_nxt  = w_ready_nxt || (w_state_nxt == S_WRITE);
    w_wen_nxt   = (w_state_nxt == S_WRITE);
    w_done_nxt  = (w_state_nxt == S_DONE);
  end

  assign Byte_Ready_Out    = r_ready;
  assign Mem_Write_En_Out  = r_wen;
  assign Mem_Addr_Out      = r_maddr;
  assign Mem_Data_Out      = r_mdata;
  assign Pipeline_Hold_Out = r_hold;
  assign Load_Done_Out     = r_done;
  assign Load_Error_Out    = r_err;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory read by the fetch stage.
- Accepts a byte stream over a valid/ready handshake and assembles bytes little-endian into 32-bit instruction words.
- Issues one word write per assembled word to the instruction memory write port.
- Holds the pipeline (fetch/decode) frozen for the whole load.
- Sits beside the fetch stage; the memory write port and Pipeline_Hold_Out feed the fetch logic.

Parameters:
- ADDR_WIDTH, 8, word-address width of the instruction memory (2^ADDR_WIDTH words).
- BASE_ADDR, 0, first word address written by every load.
- TIMEOUT_CYCLES, 1024, maximum idle cycles in RECV between accepted bytes before aborting.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Load_Start_In  in  1  single-cycle request to begin a load; sampled only in IDLE, DONE or ERROR.
- Load_Count_In  in  ADDR_WIDTH+1  number of words to load; captured with Load_Start_In.
- Byte_In  in  8  stream data byte.
- Byte_Valid_In  in  1  Byte_In is valid.
- Byte_Ready_Out  out  1  loader accepts a byte this cycle.
- Mem_Write_En_Out  out  1  instruction memory write strobe, one cycle per word.
- Mem_Addr_Out  out  ADDR_WIDTH  word address for the write.
- Mem_Data_Out  out  32  assembled instruction word.
- Pipeline_Hold_Out  out  1  freeze fetch/decode while loading.
- Load_Done_Out  out  1  one-cycle pulse on successful completion.
- Load_Error_Out  out  1  sticky abort flag.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous):
  - State returns to IDLE.
  - Every output is 0; internal address, byte index, word counter and timeout counter are 0.
  - Reset asserted mid-load abandons the load immediately; no partial word is written.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE / DONE / ERROR, when Load_Start_In=1:
  - Capture the count.
  - Set address=BASE_ADDR, byte index=0, timeout counter=0.
  - Clear Load_Error_Out.
  - Count=0: go to DONE (Load_Done_Out pulses the next cycle); no write.
  - Count≠0: go to RECV; Pipeline_Hold_Out=1 and Byte_Ready_Out=1 from the next cycle.
- RECV:
  - A transfer occurs on an edge where Byte_Valid_In && Byte_Ready_Out.
  - Byte k (0..3) is stored into bits [8k+7:8k].
  - Each transfer resets the timeout counter; otherwise it increments.
  - On the 4th transfer: go to WRITE and drop Byte_Ready_Out in that same registered update.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 with no transfer: go to ERROR; no write of the partial word.
- WRITE (exactly one cycle):
  - Mem_Write_En_Out=1 with Mem_Addr_Out and Mem_Data_Out stable; Byte_Ready_Out=0.
  - Then decrement the remaining-word count.
  - If it becomes 0: go to DONE.
  - Otherwise: address increments modulo 2^ADDR_WIDTH (wrap-around), byte index=0, go to RECV.
- DONE:
  - Load_Done_Out=1 for exactly one cycle.
  - Pipeline_Hold_Out=0 in the same cycle.
  - Returns to IDLE next cycle unless Load_Start_In=1.
- ERROR:
  - Load_Error_Out=1 and held; Pipeline_Hold_Out=0; Byte_Ready_Out=0.
  - Leaves only on Load_Start_In or reset.
- Load_Start_In while in RECV/WRITE is ignored.
- Latency:
  - Start edge T: Byte_Ready_Out high at T+1.
  - Last byte of a word accepted at edge N: Mem_Write_En_Out high in cycle N+1.
  - Final word: Load_Done_Out high in cycle N+2.
- Mem_Data_Out / Mem_Addr_Out hold their last value outside WRITE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit modulo-256 sum of all data bytes is kept.
  - After the last WRITE, state CSUM accepts one extra byte (same handshake and timeout rules).
  - If sum + byte == 0x00: go to DONE.
  - Otherwise: go to ERROR with Load_Error_Out=1. All words remain written.
- Not defined: no CSUM state; the last WRITE goes directly to DONE.

Test Plan:
- Count=1, bytes 0x13,0x00,0x50,0x00 back-to-back:
  - One write: addr 0x00, data 0x00500013.
  - Load_Done_Out pulses 2 cycles after the last byte edge.
  - Hold is 1 from start+1 through the write cycle, 0 at done.
- Count=3, Byte_Valid_In toggled every other cycle, 12 bytes:
  - Writes at addr 0,1,2 with correct words.
  - Byte_Ready_Out=0 during every WRITE cycle; no byte lost or duplicated.
- Count=0:
  - Load_Done_Out pulses at start+1.
  - No Mem_Write_En_Out and no Byte_Ready_Out.
- TIMEOUT_CYCLES=16, count=1, only 2 bytes sent:
  - Load_Error_Out=1 after 16 idle cycles; no write.
  - Next Load_Start_In clears the error and the load restarts at BASE_ADDR.
- ADDR_WIDTH=2, BASE_ADDR=3, count=2: write addresses 3 then 0.
- Reset pulse after 1.5 words of a 4-word load:
  - All outputs 0 asynchronously; no further writes.
  - A fresh load writes from BASE_ADDR.
  - With IMEM_LOADER_CHECKSUM_EN, the checksum byte 0x00-sum gives DONE; a wrong byte gives ERROR.
